// File: rtl/branchwb_arbiter_pkg.sv
// Shared types and helpers for the branch writeback arbiter.
//   BRU_NUM           : number of branch writeback lanes
//   BRWB_QUEUE_DEPTH  : default writeback queue depth (power of two, >= 2*BRU_NUM)
//   robIdx_t          : ROB index with flip bit for wrap-aware age compare
//   branchwbInfo_t    : branch writeback payload
//   rob_older()       : age compare shared with other oldest-select users
package branchwb_arbiter_pkg;

    localparam int BRU_NUM          = 2;
    localparam int BRWB_QUEUE_DEPTH = 4;
    localparam int ROB_IDX_W        = 5;
    localparam int FTQ_IDX_W        = 4;
    localparam int TARGET_W         = 16;

    typedef struct packed {
        logic                 flipped;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        robIdx_t              robIdx;
        logic [FTQ_IDX_W-1:0] ftq_idx;
        logic                 taken;
        logic [TARGET_W-1:0]  target;
    } branchwbInfo_t;

    // a is strictly older than b; equal indices are not older.
    // Differing flip bits mean the ROB wrapped between the two, so the
    // numerically larger idx is the older one.
    function automatic logic rob_older(robIdx_t a, robIdx_t b);
        return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/branchwb_arbiter_if.sv
// Bus bundle between the BRU writeback lanes, the FTQ write port and the
// ROB branch port.
//   slave  : arbiter side (consumes i_*, drives o_*)
//   master : environment side (drives i_*, consumes o_*)
interface branchwb_arbiter_if;
    import branchwb_arbiter_pkg::*;

    logic                        i_squash_vld;
    robIdx_t                     i_squash_robIdx;
    logic          [BRU_NUM-1:0] i_branchwb_vld;
    branchwbInfo_t [BRU_NUM-1:0] i_branchwbInfo;
    logic                        o_bru_stall;
    logic                        o_ftq_wb_vld;
    branchwbInfo_t               o_ftq_wbInfo;
    logic                        i_ftq_wb_rdy;
    logic                        o_rob_wb_vld;
    branchwbInfo_t               o_rob_wbInfo;
    logic                        o_empty;

    modport slave (
        input  i_squash_vld, i_squash_robIdx, i_branchwb_vld, i_branchwbInfo, i_ftq_wb_rdy,
        output o_bru_stall, o_ftq_wb_vld, o_ftq_wbInfo, o_rob_wb_vld, o_rob_wbInfo, o_empty
    );

    modport master (
        output i_squash_vld, i_squash_robIdx, i_branchwb_vld, i_branchwbInfo, i_ftq_wb_rdy,
        input  o_bru_stall, o_ftq_wb_vld, o_ftq_wbInfo, o_rob_wb_vld, o_rob_wbInfo, o_empty
    );

endinterface

// File: rtl/brwb_age_sort.sv
// Combinational age sorter for the branch writeback lanes.
// Drops lanes younger than an active squash, then packs the survivors
// oldest-first into output slots 0..o_cnt-1.
//   i_vld/i_info           : raw per-lane writebacks
//   i_squash_vld/_robIdx   : squash filter (the squashing robIdx itself survives)
//   o_vld/o_info           : survivors, oldest in slot 0, compacted
//   o_cnt                  : number of survivors
module brwb_age_sort
    import branchwb_arbiter_pkg::*;
#(
    parameter int CNT_W = $clog2(BRU_NUM + 1)
) (
    input  logic          [BRU_NUM-1:0] i_vld,
    input  branchwbInfo_t [BRU_NUM-1:0] i_info,
    input  logic                        i_squash_vld,
    input  robIdx_t                     i_squash_robIdx,
    output logic          [BRU_NUM-1:0] o_vld,
    output branchwbInfo_t [BRU_NUM-1:0] o_info,
    output logic          [CNT_W-1:0]   o_cnt
);

    localparam int RANK_W = $clog2(BRU_NUM);

    logic [BRU_NUM-1:0] w_keep;
    logic [RANK_W-1:0]  w_rank;

    always_comb begin
        for (int i = 0; i < BRU_NUM; i++) begin
            w_keep[i] = i_vld[i] &&
                        !(i_squash_vld && rob_older(i_squash_robIdx, i_info[i].robIdx));
        end
    end

    // A lane's output slot is the number of surviving lanes ahead of it.
    // Equal robIdx values are ordered by lane number so ranks stay unique.
    always_comb begin
        o_vld  = '0;
        o_info = '0;
        o_cnt  = '0;
        w_rank = '0;
        for (int i = 0; i < BRU_NUM; i++) begin
            w_rank = '0;
            for (int j = 0; j < BRU_NUM; j++) begin
                if (j != i && w_keep[j] &&
                    (rob_older(i_info[j].robIdx, i_info[i].robIdx) ||
                     (!rob_older(i_info[i].robIdx, i_info[j].robIdx) && j < i))) begin
                    w_rank = w_rank + 1'b1;
                end
            end
            if (w_keep[i]) begin
                o_vld[w_rank]  = 1'b1;
                o_info[w_rank] = i_info[i];
                o_cnt          = o_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/branchwb_arbiter.sv
// In-order branch writeback queue between the BRU writeback lanes and the
// FTQ/ROB branch interfaces.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : branchwb_arbiter_if.slave
//     i_branchwb_vld/Info  lane writebacks, enqueued oldest-first
//     i_squash_vld/robIdx  kill everything younger than the squash
//     o_ftq_wb_vld/Info    queue head toward the FTQ, popped on i_ftq_wb_rdy
//     o_rob_wb_vld/Info    registered oldest incoming branch toward the ROB
//     o_bru_stall          fewer than BRU_NUM free slots
//     o_empty              queue has no occupied slots
module branchwb_arbiter
    import branchwb_arbiter_pkg::*;
#(
    parameter int DEPTH = BRWB_QUEUE_DEPTH
) (
    input  logic clk,
    input  logic rst,
    branchwb_arbiter_if.slave bus
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            CNT_W     = $clog2(BRU_NUM + 1);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BRU_NUM_W = (AW+1)'(BRU_NUM);

    // Pointers carry the wrap bit in their MSB.
    logic [AW:0]         r_head;
    logic [AW:0]         r_tail;
    logic [DEPTH-1:0]    r_live;
    branchwbInfo_t       r_data [DEPTH];
    logic                r_rob_vld;
    branchwbInfo_t       r_rob_info;

    logic [BRU_NUM-1:0]          w_sort_vld;
    branchwbInfo_t [BRU_NUM-1:0] w_sort_info;
    logic [CNT_W-1:0]            w_sort_cnt;

    logic [AW:0]         w_count;
    logic [AW:0]         w_free;
    logic [AW:0]         w_sort_cnt_ext;
    logic [AW:0]         w_enq_n;
    logic [AW-1:0]       w_head_idx;
    logic                w_occupied;
    logic                w_head_live;
    logic                w_pop;
    logic                w_stall;
    logic [BRU_NUM-1:0]  w_wr_en;
    logic [AW-1:0]       w_wr_slot [BRU_NUM];
    logic [DEPTH-1:0]    w_live_nxt;

    brwb_age_sort #(.CNT_W(CNT_W)) u_age_sort (
        .i_vld           (bus.i_branchwb_vld),
        .i_info          (bus.i_branchwbInfo),
        .i_squash_vld    (bus.i_squash_vld),
        .i_squash_robIdx (bus.i_squash_robIdx),
        .o_vld           (w_sort_vld),
        .o_info          (w_sort_info),
        .o_cnt           (w_sort_cnt)
    );

    // Wrap-bit arithmetic makes tail-head land in 0..DEPTH directly;
    // equal indices with differing wrap bits yields DEPTH (full).
    assign w_count     = r_tail - r_head;
    assign w_free      = DEPTH_W - w_count;
    assign w_stall     = w_free < BRU_NUM_W;
    assign w_head_idx  = r_head[AW-1:0];
    assign w_occupied  = (w_count != '0);
    assign w_head_live = r_live[w_head_idx];
    // Killed heads drain without waiting for the FTQ.
    assign w_pop       = w_occupied && (!w_head_live || bus.i_ftq_wb_rdy);

    // Lanes beyond the free space are dropped (upstream violated the stall).
    always_comb begin
        w_sort_cnt_ext = {{(AW+1-CNT_W){1'b0}}, w_sort_cnt};
        w_enq_n        = (w_sort_cnt_ext > w_free) ? w_free : w_sort_cnt_ext;
        for (int k = 0; k < BRU_NUM; k++) begin
            w_wr_en[k]   = w_enq_n > (AW+1)'(k);
            w_wr_slot[k] = r_tail[AW-1:0] + AW'(k);
        end
    end

    // Pop and squash only clear live bits; freshly written slots are set last.
    // A written slot never aliases the head being popped because writes are
    // bounded by the registered free count.
    always_comb begin
        w_live_nxt = r_live;
        if (w_pop) begin
            w_live_nxt[w_head_idx] = 1'b0;
        end
        if (bus.i_squash_vld) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rob_older(bus.i_squash_robIdx, r_data[i].robIdx)) begin
                    w_live_nxt[i] = 1'b0;
                end
            end
        end
        for (int k = 0; k < BRU_NUM; k++) begin
            if (w_wr_en[k]) begin
                w_live_nxt[w_wr_slot[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_live     <= '0;
            r_rob_vld  <= 1'b0;
            r_rob_info <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_tail <= r_tail + w_enq_n;
            r_live <= w_live_nxt;
            for (int k = 0; k < BRU_NUM; k++) begin
                if (w_wr_en[k]) begin
                    r_data[w_wr_slot[k]] <= w_sort_info[k];
                end
            end
            // Squash-filtered lanes never reach here, so a younger ROB
            // entry is dropped simply by not being reloaded.
            r_rob_vld <= w_sort_vld[0];
            if (w_sort_vld[0]) begin
                r_rob_info <= w_sort_info[0];
            end
        end
    end

    // Upstream must hold off branches while stalled.
    always_ff @(posedge clk) begin
        if (!rst && w_stall) begin
            assert (w_sort_vld == '0);
        end
    end

    assign bus.o_bru_stall  = w_stall;
    assign bus.o_ftq_wb_vld = w_occupied && w_head_live;
    assign bus.o_ftq_wbInfo = r_data[w_head_idx];
    assign bus.o_rob_wb_vld = r_rob_vld;
    assign bus.o_rob_wbInfo = r_rob_info;
    assign bus.o_empty      = !w_occupied;

endmodule

// File: tb/tb_branchwb_arbiter.sv
// Directed, table-driven bench for branchwb_arbiter (DEPTH=4, BRU_NUM=2).
module tb_branchwb_arbiter;
    import branchwb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    branchwb_arbiter_if bus ();

    branchwb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] v;
        robIdx_t    r0;
        robIdx_t    r1;
        logic       sq;
        robIdx_t    sqr;
        logic       rdy;
        logic       fv;
        robIdx_t    fr;
        logic       ov;
        robIdx_t    orr;
        logic       st;
        logic       em;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic robIdx_t R(input logic f, input int i);
        robIdx_t r;
        r.flipped = f;
        r.idx     = ROB_IDX_W'(i);
        return r;
    endfunction

    function automatic branchwbInfo_t mk(input robIdx_t r);
        branchwbInfo_t b;
        b.robIdx  = r;
        b.ftq_idx = 4'd7;
        b.taken   = r.idx[0];
        b.target  = {10'h2A5, r};
        return b;
    endfunction

    function automatic vec_t V(input logic [1:0] v, input robIdx_t r0, input robIdx_t r1,
                               input logic sq, input robIdx_t sqr, input logic rdy,
                               input logic fv, input robIdx_t fr, input logic ov,
                               input robIdx_t orr, input logic st, input logic em);
        vec_t x;
        x.v = v; x.r0 = r0; x.r1 = r1; x.sq = sq; x.sqr = sqr; x.rdy = rdy;
        x.fv = fv; x.fr = fr; x.ov = ov; x.orr = orr; x.st = st; x.em = em;
        return x;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chkp(input string nm, input branchwbInfo_t act, input branchwbInfo_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input robIdx_t r0, input robIdx_t r1,
                         input logic sq, input robIdx_t sqr, input logic rdy);
        bus.i_branchwb_vld    = v;
        bus.i_branchwbInfo[0] = mk(r0);
        bus.i_branchwbInfo[1] = mk(r1);
        bus.i_squash_vld      = sq;
        bus.i_squash_robIdx   = sqr;
        bus.i_ftq_wb_rdy      = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(2'b00, R(0, 0), R(0, 0), 1'b0, R(0, 0), rdy);
    endtask

    initial begin
        robIdx_t z;
        z = R(0, 0);
        // lane order, same ftq_idx
        vecs[0]  = V(2'b11, R(0,5),  R(0,3),  0, z,       1, 1, R(0,3),  1, R(0,3),  0, 0);
        vecs[1]  = V(2'b00, z,       z,       0, z,       1, 1, R(0,5),  0, z,       0, 0);
        vecs[2]  = V(2'b00, z,       z,       0, z,       1, 0, z,       0, z,       0, 1);
        // backpressure: fill to 4, head held, drain 4 in 4 cycles
        vecs[3]  = V(2'b11, R(0,8),  R(0,9),  0, z,       0, 1, R(0,8),  1, R(0,8),  0, 0);
        vecs[4]  = V(2'b11, R(0,11), R(0,10), 0, z,       0, 1, R(0,8),  1, R(0,10), 1, 0);
        vecs[5]  = V(2'b00, z,       z,       0, z,       0, 1, R(0,8),  0, z,       1, 0);
        vecs[6]  = V(2'b00, z,       z,       0, z,       1, 1, R(0,9),  0, z,       1, 0);
        vecs[7]  = V(2'b00, z,       z,       0, z,       1, 1, R(0,10), 0, z,       0, 0);
        vecs[8]  = V(2'b00, z,       z,       0, z,       1, 1, R(0,11), 0, z,       0, 0);
        vecs[9]  = V(2'b00, z,       z,       0, z,       1, 0, z,       0, z,       0, 1);
        // squash punches a hole that drains silently
        vecs[10] = V(2'b11, R(0,2),  R(0,6),  0, z,       0, 1, R(0,2),  1, R(0,2),  0, 0);
        vecs[11] = V(2'b01, R(0,4),  z,       0, z,       0, 1, R(0,2),  1, R(0,4),  1, 0);
        vecs[12] = V(2'b00, z,       z,       1, R(0,4),  0, 1, R(0,2),  0, z,       1, 0);
        vecs[13] = V(2'b00, z,       z,       0, z,       1, 0, z,       0, z,       0, 0);
        vecs[14] = V(2'b00, z,       z,       0, z,       1, 1, R(0,4),  0, z,       0, 0);
        vecs[15] = V(2'b00, z,       z,       0, z,       1, 0, z,       0, z,       0, 1);
        // flip-bit ordering
        vecs[16] = V(2'b11, R(1,1),  R(0,30), 0, z,       1, 1, R(0,30), 1, R(0,30), 0, 0);
        vecs[17] = V(2'b00, z,       z,       0, z,       1, 1, R(1,1),  0, z,       0, 0);
        vecs[18] = V(2'b00, z,       z,       0, z,       1, 0, z,       0, z,       0, 1);
        // same-cycle squash and enqueue
        vecs[19] = V(2'b11, R(0,12), R(0,20), 1, R(0,15), 0, 1, R(0,12), 1, R(0,12), 0, 0);
        vecs[20] = V(2'b11, R(0,16), R(0,14), 1, R(0,14), 1, 1, R(0,14), 1, R(0,14), 0, 0);
        vecs[21] = V(2'b10, z,       R(0,25), 1, R(0,20), 0, 1, R(0,14), 0, z,       0, 0);
        vecs[22] = V(2'b00, z,       z,       0, z,       1, 0, z,       0, z,       0, 1);
        // squash kills a stalled head
        vecs[23] = V(2'b01, R(0,10), z,       0, z,       0, 1, R(0,10), 1, R(0,10), 0, 0);
        vecs[24] = V(2'b00, z,       z,       1, R(0,5),  0, 0, z,       0, z,       0, 0);
        vecs[25] = V(2'b00, z,       z,       0, z,       0, 0, z,       0, z,       0, 1);

        idle(1'b0);
        #3;
        chk1("rst.ftq_vld", bus.o_ftq_wb_vld, 1'b0);
        chk1("rst.rob_vld", bus.o_rob_wb_vld, 1'b0);
        chk1("rst.stall",   bus.o_bru_stall,  1'b0);
        chk1("rst.empty",   bus.o_empty,      1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].r0, vecs[i].r1, vecs[i].sq, vecs[i].sqr, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk1($sformatf("v%0d.ftq_vld", i), bus.o_ftq_wb_vld, vecs[i].fv);
            if (vecs[i].fv)
                chkp($sformatf("v%0d.ftq_info", i), bus.o_ftq_wbInfo, mk(vecs[i].fr));
            chk1($sformatf("v%0d.rob_vld", i), bus.o_rob_wb_vld, vecs[i].ov);
            if (vecs[i].ov)
                chkp($sformatf("v%0d.rob_info", i), bus.o_rob_wbInfo, mk(vecs[i].orr));
            chk1($sformatf("v%0d.stall", i), bus.o_bru_stall, vecs[i].st);
            chk1($sformatf("v%0d.empty", i), bus.o_empty, vecs[i].em);
        end

        // 3*DEPTH push/pop pairs walk both pointers around several times
        for (int k = 0; k < 3 * BRWB_QUEUE_DEPTH; k++) begin
            drive(2'b01, R(k[0], k + 1), R(0, 0), 1'b0, R(0, 0), 1'b1);
            @(posedge clk);
            #1;
            chk1($sformatf("wrap%0d.ftq_vld", k), bus.o_ftq_wb_vld, 1'b1);
            chkp($sformatf("wrap%0d.ftq_info", k), bus.o_ftq_wbInfo, mk(R(k[0], k + 1)));
            chk1($sformatf("wrap%0d.empty", k), bus.o_empty, 1'b0);
        end
        idle(1'b1);
        @(posedge clk);
        #1;
        chk1("wrap.drained", bus.o_empty, 1'b1);

        // async reset between edges with a full queue
        drive(2'b11, R(0,1), R(0,2), 1'b0, R(0,0), 1'b0);
        @(posedge clk);
        #1;
        drive(2'b11, R(0,3), R(0,4), 1'b0, R(0,0), 1'b0);
        @(posedge clk);
        #1;
        chk1("arst.pre_stall", bus.o_bru_stall, 1'b1);
        idle(1'b0);
        #2 rst = 1'b1;
        #1;
        chk1("arst.ftq_vld", bus.o_ftq_wb_vld, 1'b0);
        chk1("arst.rob_vld", bus.o_rob_wb_vld, 1'b0);
        chk1("arst.stall",   bus.o_bru_stall,  1'b0);
        chk1("arst.empty",   bus.o_empty,      1'b1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("arst.post_empty", bus.o_empty, 1'b1);
        chk1("arst.post_vld",   bus.o_ftq_wb_vld, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branchwb_arbiter.md
# branchwb_arbiter

Buffers and orders branch writebacks from the BRUs before they reach the FTQ and the ROB. It sits between the exeBlock branch writeback outputs and the backend's FTQ/ROB branch interfaces. It replaces the combinational same-FTQ-entry drop with an in-order queue, so every resolved branch reaches the FTQ through a single ready/valid write port. It also forwards the oldest branch of each cycle to the ROB and drops all entries younger than a squash.

## Interface
- BRU_NUM, `BRU_NUM (2): branch writeback lanes.
- DEPTH, 4: queue slots; power of two, ≥ 2*BRU_NUM.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- i_squash_vld  in  1  squash this cycle.
- i_squash_robIdx  in  robIdx_t  robIdx of the squashing instruction; that instruction itself is kept.
- i_branchwb_vld  in  BRU_NUM  per-lane writeback valid.
- i_branchwbInfo  in  branchwbInfo_t[BRU_NUM]  per-lane writeback payload.
- o_bru_stall  out  1  fewer than BRU_NUM free slots; BRUs must not issue branches.
- o_ftq_wb_vld  out  1  head entry valid toward the FTQ.
- o_ftq_wbInfo  out  branchwbInfo_t  head entry payload.
- i_ftq_wb_rdy  in  1  FTQ accepts the head this cycle.
- o_rob_wb_vld  out  1  registered oldest-branch valid toward the ROB.
- o_rob_wbInfo  out  branchwbInfo_t  registered oldest-branch payload.
- o_empty  out  1  no occupied slots.

## Operation
- **Storage.** Circular buffer with head/tail pointers of clog2(DEPTH) bits, plus one wrap bit each.
  - count = occupied slots (0..DEPTH), derived from pointers and wrap bits.
  - Each slot holds a live bit and a branchwbInfo_t payload.
- **Age compare** on robIdx_t {flipped, idx}:
  - A is older than B iff (A.flipped == B.flipped) ? A.idx < B.idx : A.idx > B.idx.
  - Equal robIdx means "not younger".
- **Enqueue.**
  - Valid lanes are written in age order, oldest at the tail, up to BRU_NUM per cycle.
  - Two lanes with the same ftq_idx are both enqueued, older first. Nothing is dropped.
- **Dequeue.**
  - o_ftq_wb_vld = head occupied && head live.
  - When o_ftq_wb_vld && i_ftq_wb_rdy, pop the head.
  - If the head is occupied but not live (killed), pop it silently; at most one pop per cycle.
- **Squash (i_squash_vld).**
  - Clear the live bit of every slot younger than i_squash_robIdx.
  - Same-cycle incoming lanes younger than i_squash_robIdx are not enqueued.
  - The ROB register is cleared if its content is younger.
  - Pointers are not rewound; holes drain at the head.
- **ROB path.**
  - The oldest valid incoming lane (after squash filtering) is registered into o_rob_wbInfo, with o_rob_wb_vld = 1.
  - No valid incoming lane → o_rob_wb_vld = 0 next cycle.
- **Stall.** o_bru_stall = (DEPTH − count) < BRU_NUM, computed from registered count only.
- **Overflow.** Enqueue while stalled is an illegal upstream action: the excess lanes are dropped and a simulation assertion fires.

## Timing
- Reset (asynchronous): pointers and wrap bits 0, all live bits 0, o_ftq_wb_vld=0, o_rob_wb_vld=0, o_bru_stall=0, o_empty=1. Payload registers are zeroed.
- FTQ latency: a lane enqueued in cycle N can appear at the head in cycle N+1 at the earliest.
- ROB latency: exactly 1 cycle.
- Enqueue and pop in the same cycle are both honoured. The count update is count + enq − pop.
- o_ftq_wbInfo holds stable while o_ftq_wb_vld && !i_ftq_wb_rdy, unless a squash kills the head. In that case o_ftq_wb_vld drops the next cycle.
- Pointer wrap toggles the wrap bit. Full is defined as equal pointers with differing wrap bits.
- Reset asserted mid-operation discards all contents immediately.

## Structure
- robIdx_t and branchwbInfo_t come from the backend package.
- Add to backend_define.svh:
  - `BRWB_QUEUE_DEPTH
  - rob_older function (age compare), shared with oldest_select users.
- One sub-module: brwb_age_sort. It is combinational and orders BRU_NUM lanes oldest-first with a squash filter. It feeds both the enqueue logic and the ROB register.

## Test plan
- **Lane order.** Lanes 0/1 valid with rob {0,5}/{0,3}, same ftq_idx 7, rdy=1 → FTQ sees rob 3 at cycle+1, then rob 5 at cycle+2. ROB sees rob 3 at cycle+1.
- **Backpressure.**
  - Hold rdy=0 and enqueue 2 per cycle → o_bru_stall=1 once count=3 (DEPTH=4).
  - Head payload stays constant while stalled.
  - Raising rdy drains 4 entries in 4 cycles.
- **Squash.**
  - Queue holds rob {0,2},{0,6},{0,4}; squash at {0,4} → entry {0,6} is skipped.
  - FTQ outputs exactly {0,2} then {0,4}.
  - o_empty=1 after 3 pop cycles.
- **Wrap.**
  - Robs straddle the flip: {1,1} is younger than {0,30}. Enqueue {1,1} and {0,30} together → {0,30} is enqueued first.
  - Run 3×DEPTH pushes/pops → pointer wrap with no loss.
- **Same-cycle squash and enqueue.** Incoming younger than the squash robIdx is not enqueued and does not reach the ROB; an older incoming lane is kept.
- **Async reset.** Assert rst mid-stream between clock edges → all outputs reach reset values before the next edge.
